// File: rtl/dmem_dp_pipe_pkg.sv
// ============================================================================
// Module      : dmem_dp_pipe_pkg
// Description : Shared types and constants for the dual-port data memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_dp_pipe_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic              valid;
        logic              err;
        logic [WORD_W-1:0] data;
    } rsp_t;

    // Misaligned, or any address bit above the word index set.
    function automatic logic addr_bad(input logic [WORD_W-1:0] addr, input int aw);
        return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != '0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_dp_pipe_if.sv
// ============================================================================
// Module      : dmem_dp_pipe_if
// Description : Request/response bundle for both memory ports plus ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_dp_pipe_if;
    import dmem_dp_pipe_pkg::*;

    logic              req_a, we_a, req_b, we_b;
    logic [WORD_W-1:0] addr_a, wd_a, addr_b, wd_b;
    logic [BE_W-1:0]   be_a, be_b;
    logic              ready;
    logic              rvalid_a, err_a, rvalid_b, err_b;
    logic [WORD_W-1:0] rd_a, rd_b;

    modport master (
        output req_a, we_a, addr_a, be_a, wd_a,
        output req_b, we_b, addr_b, be_b, wd_b,
        input  ready, rvalid_a, err_a, rd_a, rvalid_b, err_b, rd_b
    );

    modport slave (
        input  req_a, we_a, addr_a, be_a, wd_a,
        input  req_b, we_b, addr_b, be_b, wd_b,
        output ready, rvalid_a, err_a, rd_a, rvalid_b, err_b, rd_b
    );

endinterface

`default_nettype wire

// File: rtl/dmem_rsp_pipe.sv
// ============================================================================
// Module      : dmem_rsp_pipe
// Description : Fixed-latency response delay line carrying {valid, err, data}.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_rsp_pipe
    import dmem_dp_pipe_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  wire  clk,
    input  wire  reset,
    input  rsp_t i_rsp,
    output rsp_t o_rsp
);

    rsp_t r_stage [RD_LAT];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) r_stage[i] <= '0;
        end else begin
            r_stage[0] <= i_rsp;
            for (int i = 1; i < RD_LAT; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_rsp = r_stage[RD_LAT-1];

endmodule

`default_nettype wire

// File: rtl/dmem_dp_pipe.sv
// ============================================================================
// Module      : dmem_dp_pipe
// Description : Dual-port byte-writable data memory with power-up clear and
//               fixed-latency pipelined responses on each port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_dp_pipe
    import dmem_dp_pipe_pkg::*;
#(
    parameter int DEPTH          = 64,
    parameter int RD_LAT         = 1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input wire            clk,
    input wire            reset,
    dmem_dp_pipe_if.slave bus
);

    localparam int     c_aw        = $clog2(DEPTH);
    localparam state_t c_rst_state = CLEAR_ON_RESET ? ST_INIT : ST_RUN;

    state_t            r_state, w_state_nxt;
    logic [c_aw-1:0]   r_cnt;
    logic [WORD_W-1:0] r_mem [DEPTH];

    logic              w_ready;
    logic [c_aw-1:0]   w_idx_a, w_idx_b;
    logic              w_err_a, w_err_b, w_acc_a, w_acc_b, w_wr_a, w_wr_b;
    rsp_t              w_rsp_a, w_rsp_b, w_out_a, w_out_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_rst_state;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_INIT) r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: if (r_cnt == c_aw'(DEPTH - 1)) w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    assign w_ready = (r_state == ST_RUN) && !reset;

    assign w_idx_a = bus.addr_a[c_aw+1:2];
    assign w_idx_b = bus.addr_b[c_aw+1:2];
    assign w_err_a = addr_bad(bus.addr_a, c_aw);
    assign w_err_b = addr_bad(bus.addr_b, c_aw);
    assign w_acc_a = bus.req_a && w_ready;
    assign w_acc_b = bus.req_b && w_ready;
    assign w_wr_a  = w_acc_a && bus.we_a && !w_err_a;
    assign w_wr_b  = w_acc_b && bus.we_b && !w_err_b;

    // Port B's byte write comes second so it wins a same-byte collision.
    always_ff @(posedge clk) begin
        if ((r_state == ST_INIT) && !reset) begin
            r_mem[r_cnt] <= '0;
        end else begin
            for (int i = 0; i < BE_W; i++) begin
                if (w_wr_a && bus.be_a[i]) r_mem[w_idx_a][8*i +: 8] <= bus.wd_a[8*i +: 8];
                if (w_wr_b && bus.be_b[i]) r_mem[w_idx_b][8*i +: 8] <= bus.wd_b[8*i +: 8];
            end
        end
    end

    // Read data is captured from the array before this edge's writes land.
    always_comb begin
        w_rsp_a       = '0;
        w_rsp_a.valid = w_acc_a;
        w_rsp_a.err   = w_acc_a && w_err_a;
        if (w_acc_a && !bus.we_a && !w_err_a) w_rsp_a.data = r_mem[w_idx_a];
        w_rsp_b       = '0;
        w_rsp_b.valid = w_acc_b;
        w_rsp_b.err   = w_acc_b && w_err_b;
        if (w_acc_b && !bus.we_b && !w_err_b) w_rsp_b.data = r_mem[w_idx_b];
    end

    dmem_rsp_pipe #(.RD_LAT(RD_LAT)) u_pipe_a (
        .clk   (clk),
        .reset (reset),
        .i_rsp (w_rsp_a),
        .o_rsp (w_out_a)
    );

    dmem_rsp_pipe #(.RD_LAT(RD_LAT)) u_pipe_b (
        .clk   (clk),
        .reset (reset),
        .i_rsp (w_rsp_b),
        .o_rsp (w_out_b)
    );

    assign bus.ready    = w_ready;
    assign bus.rvalid_a = w_out_a.valid;
    assign bus.err_a    = w_out_a.err;
    assign bus.rd_a     = w_out_a.data;
    assign bus.rvalid_b = w_out_b.valid;
    assign bus.err_b    = w_out_b.err;
    assign bus.rd_b     = w_out_b.data;

endmodule

`default_nettype wire

// File: tb/tb_dmem_dp_pipe.sv
// ============================================================================
// Module      : tb_dmem_dp_pipe
// Description : Directed self-checking bench for dmem_dp_pipe (RD_LAT 2 and 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_dp_pipe;

    localparam int c_lat2 = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic rst4  = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    dmem_dp_pipe_if bus2 ();
    dmem_dp_pipe_if bus4 ();

    dmem_dp_pipe #(.DEPTH(64), .RD_LAT(2), .CLEAR_ON_RESET(1'b1)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    dmem_dp_pipe #(.DEPTH(64), .RD_LAT(4), .CLEAR_ON_RESET(1'b1)) u_dut4 (
        .clk   (clk),
        .reset (rst4),
        .bus   (bus4.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Counts negedges with ready low, noting any response seen meanwhile.
    task automatic count_init(input bit use4, output int n, output bit saw);
        n   = 0;
        saw = 1'b0;
        while (((use4 ? bus4.ready : bus2.ready) !== 1'b1) && (n < 200)) begin
            saw |= use4 ? (bus4.rvalid_a | bus4.rvalid_b) : (bus2.rvalid_a | bus2.rvalid_b);
            n++;
            @(negedge clk);
        end
    endtask

    // One cycle of requests on dut2, then check both responses RD_LAT later.
    task automatic xfer(input string tag,
                        input logic ra, input logic wa, input logic [31:0] aa,
                        input logic [3:0] bea, input logic [31:0] da,
                        input logic rb, input logic wb, input logic [31:0] ab,
                        input logic [3:0] beb, input logic [31:0] db,
                        input logic [33:0] expa, input logic [33:0] expb);
        bus2.req_a = ra; bus2.we_a = wa; bus2.addr_a = aa; bus2.be_a = bea; bus2.wd_a = da;
        bus2.req_b = rb; bus2.we_b = wb; bus2.addr_b = ab; bus2.be_b = beb; bus2.wd_b = db;
        @(negedge clk);
        bus2.req_a = 1'b0;
        bus2.req_b = 1'b0;
        repeat (c_lat2 - 1) @(negedge clk);
        check({tag, "_a"}, 64'({bus2.rvalid_a, bus2.err_a, bus2.rd_a}), 64'(expa));
        check({tag, "_b"}, 64'({bus2.rvalid_b, bus2.err_b, bus2.rd_b}), 64'(expb));
        @(negedge clk);
        check({tag, "_pulse"}, 64'({bus2.rvalid_a, bus2.rvalid_b}), 64'd0);
    endtask

    localparam logic [33:0] c_none = 34'h0;
    localparam logic [33:0] c_ok0  = {2'b10, 32'h0};
    localparam logic [33:0] c_err  = {2'b11, 32'h0};

    initial begin
        int n;
        bit saw;
        logic [33:0] pa [7];
        logic [33:0] pb [7];

        {bus2.req_a, bus2.we_a, bus2.addr_a, bus2.be_a, bus2.wd_a} = '0;
        {bus2.req_b, bus2.we_b, bus2.addr_b, bus2.be_b, bus2.wd_b} = '0;
        {bus4.req_a, bus4.we_a, bus4.addr_a, bus4.be_a, bus4.wd_a} = '0;
        {bus4.req_b, bus4.we_b, bus4.addr_b, bus4.be_b, bus4.wd_b} = '0;

        repeat (2) @(negedge clk);
        check("rst_ready", 64'(bus2.ready), 64'd0);
        check("rst_rsp", 64'({bus2.rvalid_a, bus2.err_a, bus2.rd_a, bus2.rvalid_b, bus2.err_b, bus2.rd_b}), 64'd0);

        // INIT: 64 cycles of ready low; a request held throughout is ignored.
        reset = 1'b0;
        bus2.req_a = 1'b1; bus2.we_a = 1'b0; bus2.addr_a = 32'hFC;
        count_init(1'b0, n, saw);
        bus2.req_a = 1'b0;
        check("init_cycles", 64'(n), 64'd64);
        check("init_ignored", 64'(saw), 64'd0);

        xfer("rd_fc", 1, 0, 32'hFC, 4'h0, 0, 0, 0, 0, 0, 0, c_ok0, c_none);

        xfer("wr10_full", 1, 1, 32'h10, 4'hF, 32'hAABBCCDD, 0, 0, 0, 0, 0, c_ok0, c_none);
        xfer("wr10_be5", 1, 1, 32'h10, 4'h5, 32'h11223344, 0, 0, 0, 0, 0, c_ok0, c_none);
        xfer("rd10", 1, 0, 32'h10, 4'h0, 0, 0, 0, 0, 0, 0, {2'b10, 32'hAA22CC44}, c_none);

        xfer("collide", 1, 1, 32'h20, 4'h3, 32'h11111111, 1, 1, 32'h20, 4'h6, 32'h22222222, c_ok0, c_ok0);
        xfer("rd20", 0, 0, 0, 0, 0, 1, 0, 32'h20, 4'h0, 0, c_none, {2'b10, 32'h00222211});

        xfer("wr08", 1, 1, 32'h08, 4'hF, 32'h5, 0, 0, 0, 0, 0, c_ok0, c_none);
        xfer("race", 1, 0, 32'h08, 4'h0, 0, 1, 1, 32'h08, 4'hF, 32'h9, {2'b10, 32'h5}, c_ok0);
        xfer("rd08", 1, 0, 32'h08, 4'h0, 0, 0, 0, 0, 0, 0, {2'b10, 32'h9}, c_none);

        xfer("wr00", 1, 1, 32'h0, 4'hF, 32'h12345678, 0, 0, 0, 0, 0, c_ok0, c_none);
        xfer("errs", 1, 0, 32'h102, 4'h0, 0, 1, 1, 32'h100, 4'hF, 32'hFFFFFFFF, c_err, c_err);
        xfer("rd00", 0, 0, 0, 0, 0, 1, 0, 32'h0, 4'h0, 0, c_none, {2'b10, 32'h12345678});

        xfer("wr10_be0", 1, 1, 32'h10, 4'h0, 32'h0, 0, 0, 0, 0, 0, c_ok0, c_none);
        xfer("rd10_again", 1, 0, 32'h10, 4'h0, 0, 0, 0, 0, 0, 0, {2'b10, 32'hAA22CC44}, c_none);

        // Back-to-back issue on A, plus a B read of a word A wrote one cycle earlier.
        pa = '{c_none, c_none, c_ok0, {2'b10, 32'hAA22CC44}, {2'b10, 32'h00222211}, {2'b10, 32'h9}, c_none};
        pb = '{c_none, c_none, c_none, {2'b10, 32'hCAFEF00D}, c_none, c_none, c_none};
        for (int t = 0; t < 7; t++) begin
            check($sformatf("pipe_a_t%0d", t), 64'({bus2.rvalid_a, bus2.err_a, bus2.rd_a}), 64'(pa[t]));
            check($sformatf("pipe_b_t%0d", t), 64'({bus2.rvalid_b, bus2.err_b, bus2.rd_b}), 64'(pb[t]));
            bus2.req_a = 1'b0; bus2.req_b = 1'b0; bus2.we_a = 1'b0; bus2.we_b = 1'b0;
            case (t)
                0: begin bus2.req_a = 1; bus2.we_a = 1; bus2.addr_a = 32'h40; bus2.be_a = 4'hF; bus2.wd_a = 32'hCAFEF00D; end
                1: begin bus2.req_a = 1; bus2.addr_a = 32'h10; bus2.req_b = 1; bus2.addr_b = 32'h40; end
                2: begin bus2.req_a = 1; bus2.addr_a = 32'h20; end
                3: begin bus2.req_a = 1; bus2.addr_a = 32'h08; end
                default: ;
            endcase
            @(negedge clk);
        end

        // RD_LAT=4 instance: reset lands on the edge the first response would appear.
        rst4 = 1'b0;
        count_init(1'b1, n, saw);
        check("init4_cycles", 64'(n), 64'd64);
        bus4.we_a = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus4.req_a = 1'b1; bus4.addr_a = 32'(k * 4);
            @(negedge clk);
        end
        bus4.req_a = 1'b0;
        check("flight_pre", 64'(bus4.rvalid_a), 64'd0);
        rst4 = 1'b1;
        @(negedge clk);
        check("flight_rst", 64'({bus4.ready, bus4.rvalid_a, bus4.err_a, bus4.rd_a}), 64'd0);
        rst4 = 1'b0;
        count_init(1'b1, n, saw);
        check("flight_no_rsp", 64'(saw), 64'd0);
        check("reinit4_cycles", 64'(n), 64'd64);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/dmem_dp_pipe.md
DMEM_DP_PIPE -- requirements
Module: dmem_dp_pipe

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning the number of words; it must be a power of two, at least 4.
REQ-002 SHALL have parameter RD_LAT, default 1, meaning the read latency in cycles; legal range is 1..4.
REQ-003 SHALL have parameter CLEAR_ON_RESET, default 1; when 1, memory is zeroed after reset.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  clock; all logic on posedge.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 Port x in {a,b}: req_x  in  1  access request.
REQ-008 we_x  in  1  1 means write, 0 means read.
REQ-009 addr_x  in  32  byte address; the word index is addr_x[log2(DEPTH)+1:2].
REQ-010 be_x  in  4  byte enables for writes; bit i selects bits [8i+7:8i].
REQ-011 wd_x  in  32  write data.
REQ-012 ready  out  1  shared by both ports; requests are accepted only when ready=1.
REQ-013 rvalid_x  out  1  one-cycle pulse carrying read data or an error response.
REQ-014 rd_x  out  32  read data, qualified by rvalid_x.
REQ-015 err_x  out  1  error flag, qualified by rvalid_x.

Function
REQ-016 SHALL implement state machine INIT -> RUN; ready=1 only in RUN.
REQ-017 INIT: a counter writes zero to word 0..DEPTH-1, one word per cycle, and enters RUN the cycle after word DEPTH-1 is written. INIT lasts exactly DEPTH cycles.
REQ-018 With CLEAR_ON_RESET=0, SHALL enter RUN on the first cycle after reset; memory contents are unchanged.
REQ-019 Accepted request = req_x & ready on a posedge.
REQ-020 Accepted write: bytes whose be_x bit is set are updated at that posedge; other bytes are preserved.
REQ-021 Every accepted access (read or write) SHALL produce exactly one rvalid_x pulse, RD_LAT cycles after acceptance; for writes, rd_x is 0.
REQ-022 Read data SHALL be sampled at acceptance (read-before-write): a same-cycle write from the other port to the same word is not visible to the read.
REQ-023 A read accepted in a cycle after a write to the same word SHALL return the written data.
REQ-024 Both ports writing the same word in the same cycle: bytes are merged per byte; where both ports enable a byte, port B wins.
REQ-025 Error when addr_x[1:0]!=0 or addr_x[31:log2(DEPTH)+2]!=0: no memory update, and the response is err_x=1, rd_x=0, at the normal latency.
REQ-026 A write with be_x=0 SHALL be a legal no-op with a normal response.
REQ-027 Ports SHALL be fully independent and pipelined; one accepted access per port per cycle with no stalls in RUN.
REQ-028 req_x asserted while ready=0 SHALL be ignored, with no response.
REQ-029 rvalid_x, err_x and rd_x SHALL be 0 whenever no response is due.

Reset
REQ-030 reset=1 on a posedge: state=INIT (or RUN if CLEAR_ON_RESET=0), counter=0, all response pipeline stages cleared, and ready, rvalid_x, err_x and rd_x all 0.
REQ-031 Reset mid-operation SHALL discard all in-flight responses; no rvalid pulse follows reset.
REQ-032 Reset during INIT SHALL restart the clear from word 0.
REQ-033 Memory array contents are not reset, except by the INIT clear.

Structure
REQ-034 A shared package SHALL hold the state encoding (INIT, RUN), WORD_W=32 and BE_W=4.
REQ-035 The response delay SHALL be a sub-module dmem_rsp_pipe, parametrised by RD_LAT, with one instance per port carrying {valid, err, data}.
REQ-036 The array SHALL be a single reg array of DEPTH words with byte-granular write logic.

Verification
REQ-037 Init: DEPTH=64, CLEAR_ON_RESET=1, reset for 1 cycle -> ready=0 for 64 cycles and 1 on cycle 65; a read of addr 0xFC then returns 0.
REQ-038 Byte enable: write 0xAABBCCDD to 0x10 with be=1111, then 0x11223344 with be=0101 -> read 0x10 returns 0xAA22CC44 after RD_LAT=2 cycles.
REQ-039 Collision: same cycle, A writes 0x11111111 with be=0011 and B writes 0x22222222 with be=0110 to 0x20 -> a later read returns 0x00222211.
REQ-040 Read/write race: word 0x08=0x5, then A reads 0x08 while B writes 0x9 to 0x08 -> A gets 0x5; the next read gets 0x9.
REQ-041 Errors: a read at 0x102 and a write at 0x100 (DEPTH=64) -> err=1 and rd=0 on both; word 0 is unchanged.
REQ-042 Reset mid-flight: RD_LAT=4, issue 3 reads, assert reset 2 cycles later -> no rvalid pulses, and INIT restarts.
